retire_sync_n: RTL and testbench
================================

Name: retire_sync_n

Overview:
- Parametrised N-channel successor to the two-core clock/retire synchroniser in the relational verification harness.
- Generates one divided clock per core-under-test and freezes each core after it retires an instruction. Releases all cores together once every channel has retired, so the contract checker compares retirements in lockstep.
- Adds a configurable channel count, a free-running mode, a saturating retirement counter and a sticky desynchronisation timeout.
- Sits between the harness master clock and the per-core clock pins. Its retire_o output feeds the contract checker and the control block.

Parameters:
- N_CORES, 2, number of synchronised cores (>=1)
- TIMEOUT, 64, max clk_i cycles a partial hold may last before the block declares a stall (>=1)
- CNT_W, 16, width of the retirement counter

Ports:
- clk_i  in  1  master harness clock, all state on posedge
- rst_i  in  1  synchronous active-high reset
- mode_i  in  1  0 = lockstep, 1 = free-running; latched while rst_i=1
- retire_i  in  N_CORES  per-core retire strobe (rvfi_valid)
- clk_o  out  N_CORES  per-core divided clock, registered
- retire_o  out  1  one-cycle pulse: all cores retired (lockstep only)
- retire_mask_o  out  N_CORES  registered, channels whose retirement was accepted this cycle
- retire_cnt_o  out  CNT_W  number of retire_o pulses, saturating at all-ones
- hold_o  out  N_CORES  channel currently frozen
- timeout_o  out  1  sticky stall flag

Behaviour:
- Reset (rst_i=1 at posedge):
  - clk_o=0, hold_o=0, retire_o=0, retire_mask_o=0, retire_cnt_o=0, timeout_o=0, internal timer=0.
  - mode_i is captured into mode_q; changes of mode_i outside reset are ignored.
  - Reset asserted mid-operation aborts any partial hold; the same cycle's retire_i is ignored.
- Channel RUN state (hold_o[k]=0, timeout_o=0):
  - clk_o[k] toggles every clk_i cycle, so core posedge occurs every 2 clk_i cycles.
  - retire_i[k] is sampled only in cycles where clk_o[k]=1 (core outputs settled after its posedge).
  - Accepted retire: retire_mask_o[k]=1 next cycle.
    - Lockstep: hold_o[k]<=1 and clk_o[k]<=0; it stays 0 while held.
    - Free mode: no hold; clk_o[k] keeps toggling.
- Lockstep release:
  - In the cycle after the last channel enters HOLD (all hold_o=1, including channels that entered simultaneously), retire_o=1 for exactly one cycle.
  - retire_cnt_o increments in that same cycle unless it is all-ones.
  - At the end of that cycle all hold_o clear. Every clk_o rises together the following cycle, so cores resume phase-aligned.
  - retire_mask_o is all-ones in the cycle before retire_o when all channels retire simultaneously; otherwise it shows only that cycle's acceptances.
- Timeout (lockstep only):
  - The timer counts cycles while hold_o is non-zero and not all-ones, and clears on release.
  - When the timer reaches TIMEOUT, timeout_o<=1, all clk_o<=0, all hold_o<=1 and retire_o is suppressed.
  - These outputs remain until reset.
- Free mode:
  - retire_o never asserts, retire_cnt_o stays 0, timeout_o never asserts.
- Degenerate case N_CORES=1:
  - Each accepted retire yields hold, then retire_o one cycle later, then resume.
  - Timeout is unreachable.
- retire_i asserted while clk_o[k]=0 or hold_o[k]=1 is ignored.

Test Plan:
- N=2, lockstep, both cores assert retire_i on the same clk_o-high cycle -> retire_mask_o=2'b11, retire_o pulse 1 cycle later, retire_cnt_o=1, both clk_o rise 2 cycles after acceptance.
- N=2, core0 retires 6 cycles before core1 -> hold_o=01 for 6 cycles with clk_o[0]=0; retire_o fires once, only after core1 is accepted; no timeout.
- N=3, TIMEOUT=8, core2 never retires -> timeout_o=1 exactly 8 cycles after the first hold; clk_o=000 and hold_o=111 stay fixed; retire_o never pulses afterwards.
- mode_i=1 during reset, then retire_i=11 repeatedly -> clocks never stop, retire_mask_o pulses, retire_o=0, retire_cnt_o=0.
- CNT_W=2, 5 lockstep retirements -> retire_cnt_o sequence 1,2,3,3,3.
- rst_i asserted while hold_o=01 -> next cycle all outputs zero; retire_i asserted during rst_i is ignored.

Source files
------------

// File: rtl/retire_sync_n.sv
// rtl/retire_sync_n.sv - per-core divided clocks frozen on retirement and released in lockstep
module retire_sync_n #(
  parameter int N_CORES = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
  input  logic [N_CORES-1:0] retire_i,
  output logic [N_CORES-1:0] clk_o,
  output logic               retire_o,
  output logic [N_CORES-1:0] retire_mask_o,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic [N_CORES-1:0] hold_o,
  output logic               timeout_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic               mode_q;
  logic [TW-1:0]      timer_q;
  logic [TW-1:0]      timer_inc;
  logic [N_CORES-1:0] accept;
  logic               all_hold;
  logic               partial;

  // A retire only counts once the core's posedge has settled its outputs.
  always_comb begin
    accept    = retire_i & clk_o & ~hold_o & {N_CORES{~timeout_o}};
    all_hold  = &hold_o;
    partial   = (|hold_o) && !all_hold;
    timer_inc = timer_q + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q        <= mode_i;
      clk_o         <= '0;
      hold_o        <= '0;
      retire_o      <= 1'b0;
      retire_mask_o <= '0;
      retire_cnt_o  <= '0;
      timeout_o     <= 1'b0;
      timer_q       <= '0;
    end else begin
      retire_mask_o <= accept;
      retire_o      <= 1'b0;
      if (mode_q) begin
        clk_o   <= ~clk_o;
        hold_o  <= '0;
        timer_q <= '0;
      end else if (timeout_o) begin
        clk_o  <= '0;
        hold_o <= '1;
      end else if (retire_o) begin
        // Release: every core sees its next posedge on the same cycle.
        hold_o  <= '0;
        clk_o   <= '1;
        timer_q <= '0;
      end else if (all_hold) begin
        retire_o <= 1'b1;
        if (retire_cnt_o != '1) begin
          retire_cnt_o <= retire_cnt_o + CNT_W'(1);
        end
        timer_q <= '0;
      end else if (partial && timer_inc == TW'(TIMEOUT)) begin
        timeout_o <= 1'b1;
        clk_o     <= '0;
        hold_o    <= '1;
        timer_q   <= '0;
      end else begin
        hold_o  <= hold_o | accept;
        clk_o   <= ~clk_o & ~hold_o & ~accept;
        timer_q <= partial ? timer_inc : '0;
      end
    end
  end

endmodule

// File: tb/tb_retire_sync_n.sv
// tb/tb_retire_sync_n.sv - vector table, hand sequences and reference-model random run for retire_sync_n
module tb_retire_sync_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, mode_a, rst_b, mode_b;
  logic [1:0]  ret_a;
  logic [2:0]  ret_b;
  logic [1:0]  clk_oa, mask_oa, hold_oa, cnt_oa;
  logic        retire_oa, tmo_oa;
  logic [2:0]  clk_ob, mask_ob, hold_ob;
  logic [15:0] cnt_ob;
  logic        retire_ob, tmo_ob;

  retire_sync_n #(.N_CORES(2), .TIMEOUT(64), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .mode_i(mode_a), .retire_i(ret_a),
    .clk_o(clk_oa), .retire_o(retire_oa), .retire_mask_o(mask_oa),
    .retire_cnt_o(cnt_oa), .hold_o(hold_oa), .timeout_o(tmo_oa));

  retire_sync_n #(.N_CORES(3), .TIMEOUT(8), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .mode_i(mode_b), .retire_i(ret_b),
    .clk_o(clk_ob), .retire_o(retire_ob), .retire_mask_o(mask_ob),
    .retire_cnt_o(cnt_ob), .hold_o(hold_ob), .timeout_o(tmo_ob));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] ret;
    logic [1:0] e_clk;
    logic [1:0] e_hold;
    logic       e_rto;
    logic [1:0] e_mask;
    logic [1:0] e_cnt;
    logic       e_tmo;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic m, input logic [1:0] rt, input logic [1:0] ck,
                     input logic [1:0] hd, input logic ro, input logic [1:0] mk,
                     input logic [1:0] cn, input logic to);
    vec_t v;
    v = '{r, m, rt, ck, hd, ro, mk, cn, to};
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] pack_a();
    return {2'b0, clk_oa, 2'b0, hold_oa, 2'b0, mask_oa, retire_oa, tmo_oa, 14'b0, cnt_oa, 2'b0};
  endfunction

  function automatic logic [31:0] pack_b();
    return {1'b0, clk_ob, 1'b0, hold_ob, 1'b0, mask_ob, retire_ob, tmo_ob, cnt_ob, 2'b0};
  endfunction

  // Reference model: clocks described by the parity of the cycles on which they are high,
  // retirement and timeout by the absolute cycle numbers at which they become visible.
  localparam int MN[2]   = '{2, 3};
  localparam int MTO[2]  = '{64, 8};
  localparam int MCMX[2] = '{3, 65535};

  int         t = 0;
  logic [3:0] m_held[2];
  logic [3:0] m_par[2];
  logic [3:0] m_mask[2];
  logic       m_tmo[2];
  logic       m_free[2];
  int         m_cnt[2];
  int         m_ret_at[2];
  int         m_pstart[2];

  function automatic logic [3:0] m_clk(input int i);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < MN[i]; k++)
      c[k] = !m_held[i][k] && !m_tmo[i] && ((t % 2) == int'(m_par[i][k]));
    return c;
  endfunction

  function automatic logic [31:0] m_exp(input int i);
    return {m_clk(i), m_held[i], m_mask[i], (t == m_ret_at[i]), m_tmo[i], 16'(m_cnt[i]), 2'b0};
  endfunction

  task automatic m_step(input int i, input logic rst, input logic mode, input logic [3:0] r);
    logic [3:0] full_m, acc;
    full_m = 4'((1 << MN[i]) - 1);
    if (rst) begin
      m_held[i] = '0; m_mask[i] = '0; m_tmo[i] = 1'b0; m_free[i] = mode;
      m_cnt[i] = 0; m_ret_at[i] = -1; m_pstart[i] = -1;
      m_par[i] = {4{1'(t % 2)}};
      return;
    end
    acc = m_clk(i) & r & full_m;
    m_mask[i] = acc;
    if (m_free[i] || m_tmo[i]) return;
    if (t == m_ret_at[i]) begin
      m_held[i] = '0;
      m_par[i] = {4{1'((t + 1) % 2)}};
      m_pstart[i] = -1;
    end else if (m_held[i] == full_m) begin
      if (m_ret_at[i] < t) begin
        m_ret_at[i] = t + 1;
        if (m_cnt[i] < MCMX[i]) m_cnt[i]++;
      end
    end else if (m_pstart[i] >= 0 && (t + 1 - m_pstart[i]) == MTO[i]) begin
      m_tmo[i] = 1'b1;
      m_held[i] = full_m;
    end else begin
      m_held[i] = m_held[i] | acc;
      if (m_held[i] == full_m) m_pstart[i] = -1;
      else if (m_held[i] != '0 && m_pstart[i] < 0) m_pstart[i] = t + 1;
    end
  endtask

  task automatic rtick(input logic ra_rst, input logic ma, input logic [1:0] ra,
                       input logic rb_rst, input logic mb, input logic [2:0] rb);
    rst_a = ra_rst; mode_a = ma; ret_a = ra;
    rst_b = rb_rst; mode_b = mb; ret_b = rb;
    m_step(0, ra_rst, ma, {2'b0, ra});
    m_step(1, rb_rst, mb, {1'b0, rb});
    @(posedge clk); #1;
    t++;
    check("model_a", pack_a(), m_exp(0));
    check("model_b", pack_b(), m_exp(1));
  endtask

  task automatic step_b(input logic r, input logic [2:0] rt);
    rst_b = r; mode_b = 1'b0; ret_b = rt;
    @(posedge clk); #1;
  endtask

  initial begin
    logic       ra_r, rb_r, ma, mb;
    logic [2:0] ec;

    rst_a = 1'b1; mode_a = 1'b0; ret_a = '0;
    rst_b = 1'b1; mode_b = 1'b0; ret_b = '0;

    //  rst mode ret   clk    hold  rto mask   cnt  tmo
    row(1, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b11, 2'b11, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b11, 2'b00, 2'b11, 0, 2'b11, 2'd0, 0);
    row(0, 0, 2'b11, 2'b00, 2'b11, 1, 2'b00, 2'd1, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b01, 2'b00, 2'b01, 0, 2'b01, 2'd1, 0);
    row(0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b01, 2'b00, 2'b01, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b11, 2'b10, 2'b01, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'd1, 0);
    row(0, 0, 2'b10, 2'b00, 2'b11, 0, 2'b10, 2'd1, 0);
    row(0, 0, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'd2, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd2, 0);
    row(0, 0, 2'b11, 2'b00, 2'b11, 0, 2'b11, 2'd2, 0);
    row(0, 0, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'd3, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd3, 0);
    row(0, 0, 2'b11, 2'b00, 2'b11, 0, 2'b11, 2'd3, 0);
    row(0, 0, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'd3, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd3, 0);
    row(0, 0, 2'b11, 2'b00, 2'b11, 0, 2'b11, 2'd3, 0);
    row(0, 0, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'd3, 0);
    row(0, 0, 2'b00, 2'b11, 2'b00, 0, 2'b00, 2'd3, 0);
    row(0, 0, 2'b01, 2'b00, 2'b01, 0, 2'b01, 2'd3, 0);
    row(0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 2'd3, 0);
    row(1, 0, 2'b10, 2'b00, 2'b00, 0, 2'b00, 2'd0, 0);
    row(1, 1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b11, 2'b11, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b11, 2'd0, 0);
    row(0, 1, 2'b11, 2'b11, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b11, 2'd0, 0);
    row(0, 0, 2'b01, 2'b11, 2'b00, 0, 2'b00, 2'd0, 0);
    row(0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b01, 2'd0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst; mode_a = tbl[i].mode; ret_a = tbl[i].ret;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), pack_a(),
            {2'b0, tbl[i].e_clk, 2'b0, tbl[i].e_hold, 2'b0, tbl[i].e_mask,
             tbl[i].e_rto, tbl[i].e_tmo, 14'b0, tbl[i].e_cnt, 2'b0});
    end

    // Three cores, TIMEOUT=8, core 2 never retires.
    step_b(1'b1, 3'b000);
    step_b(1'b0, 3'b000);
    check("b_clk_up", {29'b0, clk_ob}, {29'b0, 3'b111});
    step_b(1'b0, 3'b011);
    check("b_first_hold", {24'b0, clk_ob, hold_ob, retire_ob, tmo_ob}, {24'b0, 3'b000, 3'b011, 1'b0, 1'b0});
    for (int i = 1; i < 8; i++) begin
      step_b(1'b0, 3'b011);
      ec = {1'(i % 2), 2'b00};
      check($sformatf("b_wait%0d", i), {24'b0, clk_ob, hold_ob, retire_ob, tmo_ob},
            {24'b0, ec, 3'b011, 1'b0, 1'b0});
    end
    step_b(1'b0, 3'b000);
    check("b_timeout", {24'b0, clk_ob, hold_ob, retire_ob, tmo_ob}, {24'b0, 3'b000, 3'b111, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++) begin
      step_b(1'b0, 3'b111);
      check($sformatf("b_stuck%0d", i), {8'b0, clk_ob, hold_ob, mask_ob, retire_ob, tmo_ob, cnt_ob},
            {8'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 16'd0});
    end

    for (int c = 0; c < 2400; c++) begin
      ra_r = (c == 0) || ($urandom_range(0, 99) == 0);
      rb_r = (c == 0) || ($urandom_range(0, 59) == 0);
      ma   = ($urandom_range(0, 3) == 0);
      mb   = ($urandom_range(0, 3) == 0);
      rtick(ra_r, ma, 2'($urandom_range(0, 3)), rb_r, mb, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
